// File: rtl/tt_um_hoene_protocol_pkg.sv
// Shared types and helpers for the protocol frame controller.
// Holds the frame state enum, the fault codes reported on err_code,
// and the small arithmetic helpers used by the frame sequencer.
package tt_um_hoene_protocol_pkg;

    // Frame walk: sync -> header -> payload -> checksum, with a resync detour
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_RESYNC  = 3'd4
    } state_t;

    // Fault codes; err_code holds the last one until a good frame ends
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_CSUM = 3'd2;
    localparam logic [2:0] ERR_OVR  = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;
    localparam logic [2:0] ERR_LOST = 3'd5;

    // Running frame checksum: plain 8-bit XOR over header and payload
    function automatic logic [7:0] csum_next(input logic [7:0] acc,
                                             input logic [7:0] data);
        csum_next = acc ^ data;
    endfunction

    // A header length is legal when it is 1..max_len (unsigned compare)
    function automatic logic len_ok(input logic [7:0] n,
                                    input logic [7:0] max_len);
        len_ok = (n != 8'd0) && (n <= max_len);
    endfunction

endpackage

// File: rtl/tt_um_hoene_protocol_deser.sv
// Bit-to-byte deserialiser for the frame controller.
// Shifts in one bit per strobe, MSB first. byte_done is a registered
// one-cycle pulse in the cycle after the 8th strobe, while byte_out
// holds the completed byte. clear discards any partial byte.
module tt_um_hoene_protocol_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       bit_clk,
    input  logic       bit_data,
    output logic [7:0] byte_out,
    output logic       byte_done
);

    logic [7:0] shreg;
    logic [2:0] cnt;

    // Shift register, bit counter and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= 8'd0;
            cnt       <= 3'd0;
            byte_done <= 1'b0;
        end else if (clear) begin
            shreg     <= 8'd0;
            cnt       <= 3'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (bit_clk) begin
                shreg <= {shreg[6:0], bit_data};
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    byte_done <= 1'b1;
                end else begin
                    byte_done <= 1'b0;
                end
            end else begin
                shreg <= shreg;
                cnt   <= cnt;
            end
        end
    end

    assign byte_out = shreg;

endmodule

// File: rtl/tt_um_hoene_protocol_frame_ctrl.sv
// Frame sequencer behind the bit-level sync detector.
// Deserialises qualified bits into bytes, validates the length header,
// streams payload bytes out on a valid/ready port, verifies the XOR
// checksum, and pulses resync into the detector on any protocol fault.
// Good frames chain back-to-back without a fresh sync word.
module tt_um_hoene_protocol_frame_ctrl
    import tt_um_hoene_protocol_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       insync,
    input  logic       bit_data,
    input  logic       bit_clk,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_done,
    output logic       resync,
    output logic [2:0] err_code
);

    localparam int               TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    state_t           state;
    logic [7:0]       csum;
    logic [7:0]       remaining;
    logic [TMR_W-1:0] timer;

    logic [7:0]       rx_byte;
    logic             byte_done;

    logic             in_frame;
    logic             deser_clear;
    logic             timed_out;
    logic             overrun;
    logic             go_resync;
    logic [2:0]       fault_code;

    // Bits are only assembled while a frame is open; IDLE and RESYNC
    // hold the deserialiser cleared so stray strobes are dropped.
    tt_um_hoene_protocol_deser u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (deser_clear),
        .bit_clk   (bit_clk),
        .bit_data  (bit_data),
        .byte_out  (rx_byte),
        .byte_done (byte_done)
    );

    // Frame-open decode and the raw timeout / overrun conditions
    always_comb begin
        in_frame = 1'b0;
        case (state)
            ST_HEADER, ST_PAYLOAD, ST_CHECK: in_frame = 1'b1;
            default:                         in_frame = 1'b0;
        endcase
        deser_clear = ~in_frame;
        // The timer steps to TIMEOUT on this edge when no strobe arrives
        timed_out   = in_frame & ~bit_clk & (timer == TMR_LAST);
        // A new payload byte while the previous one is still unaccepted
        overrun     = (state == ST_PAYLOAD) & byte_done & byte_valid & ~byte_ready;
    end

    // Fault arbitration below sync loss: timeout > overrun > length/checksum
    always_comb begin
        go_resync  = 1'b0;
        fault_code = ERR_NONE;
        if (timed_out) begin
            go_resync  = 1'b1;
            fault_code = ERR_TMO;
        end else if (overrun) begin
            go_resync  = 1'b1;
            fault_code = ERR_OVR;
        end else if (byte_done && (state == ST_HEADER) && !len_ok(rx_byte, MAX_LEN_B)) begin
            go_resync  = 1'b1;
            fault_code = ERR_LEN;
        end else if (byte_done && (state == ST_CHECK) && (rx_byte != csum)) begin
            go_resync  = 1'b1;
            fault_code = ERR_CSUM;
        end else begin
            go_resync  = 1'b0;
            fault_code = ERR_NONE;
        end
    end

    // Inter-strobe timer: cleared by every strobe and outside a frame, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= TMR_ZERO;
        end else if (!in_frame || bit_clk) begin
            timer <= TMR_ZERO;
        end else if (timer != TMR_MAX) begin
            timer <= timer + TMR_ONE;
        end else begin
            timer <= timer;
        end
    end

    // Frame FSM with registered handshake, pulse and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            byte_data  <= 8'd0;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            resync     <= 1'b0;
            err_code   <= ERR_NONE;
            csum       <= 8'd0;
            remaining  <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            resync     <= 1'b0;
            // Accepted byte drops valid next cycle; a new byte may override below
            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end else begin
                byte_valid <= byte_valid;
            end

            case (state)
                ST_IDLE: begin
                    csum      <= 8'd0;
                    remaining <= 8'd0;
                    // First locked strobe is the last sync bit; it is not data
                    if (insync && bit_clk) begin
                        state <= ST_HEADER;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_HEADER, ST_PAYLOAD, ST_CHECK: begin
                    if (!insync) begin
                        // Detector already unlocked: no resync pulse needed
                        err_code   <= ERR_LOST;
                        state      <= ST_IDLE;
                        byte_valid <= 1'b0;
                        csum       <= 8'd0;
                        remaining  <= 8'd0;
                    end else if (go_resync) begin
                        err_code   <= fault_code;
                        state      <= ST_RESYNC;
                        resync     <= 1'b1;
                        byte_valid <= 1'b0;
                    end else if (byte_done) begin
                        case (state)
                            ST_HEADER: begin
                                csum      <= rx_byte;
                                remaining <= rx_byte;
                                state     <= ST_PAYLOAD;
                            end
                            ST_PAYLOAD: begin
                                byte_data  <= rx_byte;
                                byte_valid <= 1'b1;
                                csum       <= csum_next(csum, rx_byte);
                                remaining  <= remaining - 8'd1;
                                if (remaining == 8'd1) begin
                                    state <= ST_CHECK;
                                end else begin
                                    state <= ST_PAYLOAD;
                                end
                            end
                            ST_CHECK: begin
                                // Checksum matched: chain straight into the next header
                                frame_done <= 1'b1;
                                err_code   <= ERR_NONE;
                                csum       <= 8'd0;
                                remaining  <= 8'd0;
                                state      <= ST_HEADER;
                            end
                            default: begin
                                state <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state <= state;
                    end
                end

                ST_RESYNC: begin
                    state      <= ST_IDLE;
                    byte_valid <= 1'b0;
                    csum       <= 8'd0;
                    remaining  <= 8'd0;
                    if (!insync) begin
                        err_code <= ERR_LOST;
                    end else begin
                        err_code <= err_code;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_protocol_frame_ctrl.sv
// Self-checking bench for the protocol frame controller.
// A frame-level reference model follows the stimulus and a compare
// process checks every output on each falling edge; directed scenarios
// add hand-computed literal expectations.
module tb_tt_um_hoene_protocol_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       insync = 1'b0;
    logic       bit_data = 1'b0;
    logic       bit_clk = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_done;
    logic       resync;
    logic [2:0] err_code;

    int checks = 0;
    int passes = 0;

    // reference model: phase 0 idle, 1 header, 2 payload, 3 checksum, 4 resync
    int         m_phase;
    int         m_bits;
    int         m_quiet;
    int         m_left;
    logic [7:0] m_acc;
    logic [7:0] m_pbyte;
    logic [7:0] m_sum;
    bit         m_pend;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_done;
    bit         e_resync;
    logic [2:0] e_err;

    logic [7:0] got[$];
    int n_done = 0;
    int n_resync = 0;
    int n_valid = 0;

    tt_um_hoene_protocol_frame_ctrl #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .insync     (insync),
        .bit_data   (bit_data),
        .bit_clk    (bit_clk),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_done (frame_done),
        .resync     (resync),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_bits = 0; m_quiet = 0; m_left = 0;
        m_acc = 8'd0; m_pbyte = 8'd0; m_sum = 8'd0; m_pend = 1'b0;
        e_data = 8'd0; e_valid = 1'b0; e_done = 1'b0; e_resync = 1'b0; e_err = 3'd0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit         have;
        bit         tmo;
        bit         fault;
        logic [7:0] b;
        int         p;
        have = m_pend;
        b = m_pbyte;
        m_pend = 1'b0;
        p = m_phase;
        e_done = 1'b0;
        e_resync = 1'b0;
        tmo = 1'b0;
        fault = 1'b0;
        if (e_valid && byte_ready) e_valid = 1'b0;
        if (p >= 1 && p <= 3) begin
            if (bit_clk) begin
                m_quiet = 0;
                m_acc = {m_acc[6:0], bit_data};
                m_bits++;
                if (m_bits == 8) begin
                    m_bits = 0;
                    m_pend = 1'b1;
                    m_pbyte = m_acc;
                end
            end else if (m_quiet < TIMEOUT) begin
                m_quiet++;
                tmo = (m_quiet == TIMEOUT);
            end
        end else begin
            m_quiet = 0; m_bits = 0; m_acc = 8'd0;
        end
        case (p)
            0: if (insync && bit_clk) m_phase = 1;
            4: begin
                m_phase = 0;
                e_valid = 1'b0;
                if (!insync) e_err = 3'd5;
            end
            default: begin
                if (!insync) begin
                    e_err = 3'd5; m_phase = 0; e_valid = 1'b0;
                end else if (tmo) begin
                    e_err = 3'd4; fault = 1'b1;
                end else if (p == 2 && have && e_valid && !byte_ready) begin
                    e_err = 3'd3; fault = 1'b1;
                end else if (have) begin
                    if (p == 1) begin
                        if (b == 8'd0 || b > MAX_LEN) begin
                            e_err = 3'd1; fault = 1'b1;
                        end else begin
                            m_sum = b; m_left = b; m_phase = 2;
                        end
                    end else if (p == 2) begin
                        e_data = b; e_valid = 1'b1; m_sum = m_sum ^ b; m_left--;
                        if (m_left == 0) m_phase = 3;
                    end else begin
                        if (b == m_sum) begin
                            e_done = 1'b1; e_err = 3'd0; m_phase = 1;
                        end else begin
                            e_err = 3'd2; fault = 1'b1;
                        end
                    end
                end
                if (fault) begin
                    m_phase = 4; e_resync = 1'b1; e_valid = 1'b0;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_data = b;
        bit_clk = 1'b1;
        step();
        bit_clk = 1'b0;
        step();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic lock();
        insync = 1'b1;
        send_bit(1'b1);
    endtask

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        chk("byte_valid", byte_valid, e_valid);
        chk("byte_data", byte_data, e_data);
        chk("frame_done", frame_done, e_done);
        chk("resync", resync, e_resync);
        chk("err_code", err_code, e_err);
        chk("done_resync_excl", frame_done & resync, 0);
        if (byte_valid && byte_ready) got.push_back(byte_data);
        if (frame_done) n_done++;
        if (resync) n_resync++;
        if (byte_valid) n_valid++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int r0;
        int v0;
        int n;
        model_reset();
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_resync", resync, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // 1: good frame, bytes A5 3C, checksum 9B
        byte_ready = 1'b1;
        got.delete();
        d0 = n_done;
        lock();
        send_byte(8'h02); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h9B);
        chk("t1_frame_done", frame_done, 1);
        chk("t1_err", err_code, 0);
        step();
        chk("t1_done_width", frame_done, 0);
        chk("t1_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t1_byte0", got[0], 8'hA5);
            chk("t1_byte1", got[1], 8'h3C);
        end
        chk("t1_ndone", n_done - d0, 1);

        // 2: same frame, bad checksum
        d0 = n_done; r0 = n_resync;
        send_byte(8'h02); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h9A);
        chk("t2_resync", resync, 1);
        chk("t2_err", err_code, 2);
        step();
        chk("t2_resync_width", resync, 0);
        chk("t2_ndone", n_done - d0, 0);
        chk("t2_nresync", n_resync - r0, 1);

        // 3: illegal lengths 0x00 and 0x11
        v0 = n_valid; r0 = n_resync;
        lock(); send_byte(8'h00);
        chk("t3a_resync", resync, 1);
        chk("t3a_err", err_code, 1);
        step();
        lock(); send_byte(8'h11);
        chk("t3b_resync", resync, 1);
        chk("t3b_err", err_code, 1);
        step();
        chk("t3_no_valid", n_valid - v0, 0);
        chk("t3_nresync", n_resync - r0, 2);

        // 4: sink stalled, second byte overruns
        byte_ready = 1'b0;
        lock(); send_byte(8'h02); send_byte(8'hA5);
        chk("t4_valid_held", byte_valid, 1);
        chk("t4_data_held", byte_data, 8'hA5);
        send_byte(8'h3C);
        chk("t4_resync", resync, 1);
        chk("t4_valid_drop", byte_valid, 0);
        chk("t4_err", err_code, 3);
        step();
        byte_ready = 1'b1;

        // 5a: strobes stop after 3 payload bits
        lock(); send_byte(8'h02);
        send_bit(1'b1); send_bit(1'b0);
        bit_data = 1'b1; bit_clk = 1'b1;
        step();
        bit_clk = 1'b0;
        n = 0;
        while (n < 400 && !resync) begin
            step();
            n++;
        end
        chk("t5_timeout_cycles", n, TIMEOUT);
        chk("t5_err_tmo", err_code, 4);
        step();

        // 5b: sync lost mid-payload
        r0 = n_resync;
        lock(); send_byte(8'h02); send_byte(8'hA5);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        insync = 1'b0;
        step();
        chk("t5_err_lost", err_code, 5);
        chk("t5_lost_no_resync", resync, 0);
        insync = 1'b1;
        repeat (3) step();
        chk("t5_lost_nresync", n_resync - r0, 0);

        // 6: two back-to-back frames, then reset mid-payload
        got.delete();
        d0 = n_done;
        lock();
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        send_byte(8'h03); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h03);
        step();
        chk("t6_ndone", n_done - d0, 2);
        chk("t6_err", err_code, 0);
        chk("t6_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("t6_byte0", got[0], 8'h42);
            chk("t6_byte3", got[3], 8'h30);
        end
        byte_ready = 1'b0;
        send_byte(8'h02); send_byte(8'hA5);
        chk("t6_pre_rst_valid", byte_valid, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_valid", byte_valid, 0);
        chk("t6_rst_data", byte_data, 0);
        chk("t6_rst_err", err_code, 0);
        chk("t6_rst_resync", resync, 0);
        chk("t6_rst_done", frame_done, 0);
        repeat (2) step();
        rst_n = 1'b1;
        byte_ready = 1'b1;
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
